// File: rtl/super_pkg.sv
// Shared types and constants for the super-scalar core's ALU issue path.
package super_pkg;

    localparam int NPendDefault = 3;

    typedef struct packed {
        logic [1:0] valid;
        logic [4:0] rd0;
        logic [4:0] rd1;
    } waw_act_t;

endpackage

// File: rtl/alupl_sb_cnt.sv
// One scoreboard entry: count of in-flight writes to a single architectural
// register, with two increment and two decrement requests per cycle.
module alupl_sb_cnt
    import super_pkg::*;
#(
    parameter int NPend = NPendDefault
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [1:0]       inc_i,
    input  logic [1:0]       dec_i,
    output logic [NPend-1:0] cnt_o,
    output logic             sat_o
);

    localparam int CntMax = (1 << NPend) - 1;

    logic [NPend-1:0] cnt_q;
    logic [NPend-1:0] cnt_d;
    logic             underflow;
    int               sum;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        sum       = int'(cnt_q) + int'(inc_i[0]) + int'(inc_i[1])
                  - int'(dec_i[0]) - int'(dec_i[1]);
        underflow = 1'b0;
        cnt_d     = NPend'(sum);
        if (sum < 0) begin
            underflow = 1'b1;
            cnt_d     = '0;
        end else if (sum > CntMax) begin
            cnt_d = NPend'(CntMax);
        end
    end

    // NOTE: the scoreboard gates issue, so every counter is reset like any other
    // control flop rather than treated as uninitialised storage; sequential state
    // uses non-blocking assignments so all counters sample pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == NPend'(CntMax));

    // A commit without a matching in-flight write means the issuer/commit protocol broke.
    assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i) !underflow);

endmodule

// File: rtl/alupl_issue_sched.sv
// Dual-slot in-order issue scheduler for the two ALU pipelines with a RAW/WAW
// scoreboard. Define ALUPL_SCHED_RR_EN for round-robin pipeline steering.
module alupl_issue_sched
    import super_pkg::*;
#(
    parameter int NPend = NPendDefault
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [1:0]      slot_valid_i,
    input  logic [1:0]      slot_rf_we_i,
    input  logic [1:0][4:0] slot_rd_i,
    input  logic [1:0][4:0] slot_rs1_i,
    input  logic [1:0][4:0] slot_rs2_i,
    input  logic [1:0][1:0] slot_rs_used_i,
    output logic [1:0]      slot_accept_o,
    input  logic [1:0]      pl_rdy_i,
    output logic [1:0]      pl_valid_o,
    output logic [1:0]      pl_src_o,
    input  logic [1:0][31:0] fwd_act_i,
    input  logic [1:0]      cmt_we_i,
    input  logic [1:0][4:0] cmt_waddr_i,
    output waw_act_t        waw_act_o
);

    localparam int CntMax = (1 << NPend) - 1;

    logic [31:0] pend_nz;
    logic [31:0] pend_sat;
    logic [31:0] pend_hi;
    logic [31:0] fwd_any;
    logic [1:0]  wr;
    logic [1:0]  raw_ok;
    logic [1:0]  issue;
    logic [1:0]  wr_issue;
    logic        haz1;
    logic        same_rd;
    logic        sat0;
    logic        sat1;
    logic        ptr;

    assign fwd_any  = fwd_act_i[0] | fwd_act_i[1];
    assign wr_issue = issue & wr;

    // Entry 0 has no counter: x0 never pends, which also makes it always RAW-satisfied.
    for (genvar r = 0; r < 32; r++) begin : g_sb
        if (r == 0) begin : g_zero
            assign pend_nz[r]  = 1'b0;
            assign pend_sat[r] = 1'b0;
            assign pend_hi[r]  = 1'b0;
        end else begin : g_cnt
            logic [1:0]       inc;
            logic [1:0]       dec;
            logic [NPend-1:0] cnt;
            logic             sat;

            assign inc = {wr_issue[1] && (slot_rd_i[1] == 5'(r)),
                          wr_issue[0] && (slot_rd_i[0] == 5'(r))};
            assign dec = {cmt_we_i[1] && (cmt_waddr_i[1] == 5'(r)),
                          cmt_we_i[0] && (cmt_waddr_i[0] == 5'(r))};

            alupl_sb_cnt #(
                .NPend (NPend)
            ) u_cnt (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .flush_i (flush_i),
                .inc_i   (inc),
                .dec_i   (dec),
                .cnt_o   (cnt),
                .sat_o   (sat)
            );

            assign pend_nz[r]  = |cnt;
            assign pend_sat[r] = sat;
            assign pend_hi[r]  = (cnt == NPend'(CntMax - 1));
        end
    end

`ifdef ALUPL_SCHED_RR_EN
    logic ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else if (flush_i) begin
            ptr_q <= 1'b0;
        end else if (issue[0] ^ issue[1]) begin
            ptr_q <= ~ptr_q;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = 1'b0;
`endif

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            wr[s]     = slot_rf_we_i[s] && (slot_rd_i[s] != 5'd0);
            raw_ok[s] = (!slot_rs_used_i[s][0] || !pend_nz[slot_rs1_i[s]] || fwd_any[slot_rs1_i[s]])
                     && (!slot_rs_used_i[s][1] || !pend_nz[slot_rs2_i[s]] || fwd_any[slot_rs2_i[s]]);
        end
    end

    // Slot 1 sees slot 0's increment: a pair writing one register at max-1 would overflow it.
    always_comb begin
        haz1    = wr[0] && ((slot_rs_used_i[1][0] && (slot_rs1_i[1] == slot_rd_i[0]))
                         || (slot_rs_used_i[1][1] && (slot_rs2_i[1] == slot_rd_i[0])));
        same_rd = wr[0] && wr[1] && (slot_rd_i[0] == slot_rd_i[1]);
        sat0    = wr[0] && pend_sat[slot_rd_i[0]];
        sat1    = wr[1] && (pend_sat[slot_rd_i[1]] || (same_rd && pend_hi[slot_rd_i[1]]));

        issue    = 2'b00;
        issue[0] = !flush_i && slot_valid_i[0] && raw_ok[0] && !sat0 && pl_rdy_i[ptr];
        issue[1] = issue[0] && slot_valid_i[1] && raw_ok[1] && !haz1 && !sat1 && pl_rdy_i[!ptr];
    end

    always_comb begin
        slot_accept_o = issue;
        pl_valid_o    = 2'b00;
        pl_src_o      = 2'b00;
        waw_act_o     = '0;

        if (issue[0]) begin
            pl_valid_o[ptr] = 1'b1;
        end
        if (issue[1]) begin
            pl_valid_o[!ptr] = 1'b1;
            pl_src_o[!ptr]   = 1'b1;
        end

        if (wr_issue[0]) begin
            waw_act_o.valid[0] = pend_nz[slot_rd_i[0]];
            waw_act_o.rd0      = slot_rd_i[0];
        end
        if (wr_issue[1]) begin
            waw_act_o.valid[1] = pend_nz[slot_rd_i[1]] || same_rd;
            waw_act_o.rd1      = slot_rd_i[1];
        end
    end

endmodule
